// File: rtl/bcd_to_excess3_serial_if.sv
// Purpose : serial BCD-in / Excess-3-out bit stream bundle.
// Latency : n/a (signal grouping only).
// Backpressure: none; one bit per clock, no gaps between digits.
// Ports   : x    - serial BCD bit, LSB first, four cycles per digit
//           z    - serial Excess-3 bit, bit-aligned with x
//           last - high while x carries bit 3 of a digit
//           err  - high on the bit-3 cycle of a digit greater than 9
interface bcd_to_excess3_serial_if;
   logic x;
   logic z;
   logic last;
   logic err;

   // master drives the BCD stream and observes the converted stream
   modport master (output x, input z, input last, input err);
   // slave is the converter itself
   modport slave  (input x, output z, output last, output err);
endinterface

// File: rtl/bcd_to_excess3_serial.sv
// Purpose : serial BCD to Excess-3 converter (adds 0011 LSB first, mod 16).
// Latency : zero; z/last/err are Mealy outputs, combinational from state and x.
// Backpressure: none; accepts one bit every clock, digits back-to-back.
// Ports   : clk  - single clock, rising edge
//           rst  - synchronous active-high reset; forces outputs low
//           bus  - slave side of bcd_to_excess3_serial_if (x in; z, last, err out)
// Parameter CHECK_BCD: nonzero enables err, zero ties err low.
module bcd_to_excess3_serial #(
   parameter int CHECK_BCD = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   bcd_to_excess3_serial_if.slave        bus
);

   // Sn_Cc_Hh: expecting bit n, pending carry c, h = a 1 seen on bit 1 or 2.
   // S3_C1_H0 cannot actually be reached (a carry into bit 3 needs bit 2 = 1,
   // which sets h) but is kept so every carry/flag combination is decoded.
   typedef enum logic [3:0] {
      S0       = 4'd0,
      S1_C0    = 4'd1,
      S1_C1    = 4'd2,
      S2_C0_H0 = 4'd3,
      S2_C0_H1 = 4'd4,
      S2_C1_H0 = 4'd5,
      S2_C1_H1 = 4'd6,
      S3_C0_H0 = 4'd7,
      S3_C0_H1 = 4'd8,
      S3_C1_H0 = 4'd9,
      S3_C1_H1 = 4'd10
   } state_t;

   localparam logic chk_en = (CHECK_BCD != 0);

   state_t state;
   logic   x;
   logic   z_c;
   logic   last_c;
   logic   err_c;

   assign x = bus.x;

   // State register. Bit 0 adds 1, bit 1 adds 1 + carry, bits 2/3 add the
   // carry only; carry out of bit 3 is dropped, giving the mod-16 result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S0;
      end else begin
         case (state)
            S0:       state <= x ? S1_C1 : S1_C0;
            // bit 1: carry' = x | c, h' = x
            S1_C0:    state <= x ? S2_C1_H1 : S2_C0_H0;
            S1_C1:    state <= x ? S2_C1_H1 : S2_C1_H0;
            // bit 2: carry' = x & c, h' = h | x
            S2_C0_H0: state <= x ? S3_C0_H1 : S3_C0_H0;
            S2_C0_H1: state <= S3_C0_H1;
            S2_C1_H0: state <= x ? S3_C1_H1 : S3_C0_H0;
            S2_C1_H1: state <= x ? S3_C1_H1 : S3_C0_H1;
            // bit 3: digit complete, next cycle is bit 0 of the next digit
            S3_C0_H0,
            S3_C0_H1,
            S3_C1_H0,
            S3_C1_H1: state <= S0;
            default:  state <= S0;
         endcase
      end
   end

   // Mealy outputs. Held low during reset and in unused encodings.
   always_comb begin
      z_c    = 1'b0;
      last_c = 1'b0;
      err_c  = 1'b0;
      if (!rst) begin
         case (state)
            S0:       z_c = ~x;
            // ~(x ^ c): c = 0 gives ~x, c = 1 gives x
            S1_C0:    z_c = ~x;
            S1_C1:    z_c = x;
            // x ^ c
            S2_C0_H0,
            S2_C0_H1: z_c = x;
            S2_C1_H0,
            S2_C1_H1: z_c = ~x;
            S3_C0_H0: begin
               z_c    = x;
               last_c = 1'b1;
            end
            S3_C0_H1: begin
               z_c    = x;
               last_c = 1'b1;
               // bit 3 set together with bit 1 or 2 means digit >= 10
               err_c  = chk_en & x;
            end
            S3_C1_H0: begin
               z_c    = ~x;
               last_c = 1'b1;
            end
            S3_C1_H1: begin
               z_c    = ~x;
               last_c = 1'b1;
               err_c  = chk_en & x;
            end
            default: begin
               z_c    = 1'b0;
               last_c = 1'b0;
               err_c  = 1'b0;
            end
         endcase
      end
   end

   assign bus.z    = z_c;
   assign bus.last = last_c;
   assign bus.err  = err_c;

endmodule

// File: tb/tb_bcd_to_excess3_serial.sv
// Purpose : directed/table and random checks of bcd_to_excess3_serial.
// Latency : outputs compared on the falling edge of the cycle x is driven.
// Backpressure: none; digits are driven back-to-back.
`timescale 1ns/1ps
module tb_bcd_to_excess3_serial;

   logic clk;
   logic rst;
   int   n_total;
   int   n_pass;

   bcd_to_excess3_serial_if bus_chk ();
   bcd_to_excess3_serial_if bus_nochk ();

   bcd_to_excess3_serial #(.CHECK_BCD(1)) u_chk (
      .clk (clk),
      .rst (rst),
      .bus (bus_chk)
   );

   bcd_to_excess3_serial #(.CHECK_BCD(0)) u_nochk (
      .clk (clk),
      .rst (rst),
      .bus (bus_nochk)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
      $fatal(1);
   end

   typedef struct {
      logic [3:0] digit;
      logic [3:0] exp_z;
      logic       exp_err;
   } vec_t;

   task automatic chk(input string nm, input logic act, input logic exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b required %b", nm, act, exp);
   endtask

   task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", nm, act, exp);
   endtask

   // Called just after a rising edge: drive x, check on falling edge,
   // then advance to just after the next rising edge.
   task automatic cyc(input logic b, input logic ez, input logic el,
                      input logic ee, input string nm);
      bus_chk.x   = b;
      bus_nochk.x = b;
      @(negedge clk);
      chk({nm, " z"},       bus_chk.z,    ez);
      chk({nm, " last"},    bus_chk.last, el);
      chk({nm, " err"},     bus_chk.err,  ee);
      chk({nm, " err_off"}, bus_nochk.err, 1'b0);
      chk({nm, " z_off"},   bus_nochk.z,  ez);
      @(posedge clk);
      #1;
   endtask

   task automatic run_digit(input logic [3:0] d, input logic [3:0] ez,
                            input logic ee, input string nm);
      for (int i = 0; i < 4; i++) begin
         cyc(d[i], ez[i], (i == 3), ee && (i == 3), $sformatf("%s b%0d", nm, i));
      end
   endtask

   // Random digit: recover z LSB first and record whether err fired.
   task automatic rand_digit(input logic [3:0] d, output logic [3:0] zr,
                             output logic err_seen);
      zr       = 4'h0;
      err_seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus_chk.x   = d[i];
         bus_nochk.x = d[i];
         @(negedge clk);
         zr[i] = bus_chk.z;
         if (bus_chk.err === 1'b1) err_seen = 1'b1;
         @(posedge clk);
         #1;
      end
   endtask

   vec_t vecs [12];

   initial begin
      logic [3:0] d;
      logic [3:0] zr;
      logic       es;
      logic       exp_es;
      int         bad_conv;
      int         bad_err;

      n_total = 0;
      n_pass  = 0;

      vecs[0]  = '{4'd0,  4'h3, 1'b0};
      vecs[1]  = '{4'd9,  4'hC, 1'b0};
      vecs[2]  = '{4'd10, 4'hD, 1'b1};
      vecs[3]  = '{4'd5,  4'h8, 1'b0};
      vecs[4]  = '{4'd7,  4'hA, 1'b0};
      vecs[5]  = '{4'd3,  4'h6, 1'b0};
      vecs[6]  = '{4'd15, 4'h2, 1'b1};
      vecs[7]  = '{4'd11, 4'hE, 1'b1};
      vecs[8]  = '{4'd8,  4'hB, 1'b0};
      vecs[9]  = '{4'd6,  4'h9, 1'b0};
      vecs[10] = '{4'd14, 4'h1, 1'b1};
      vecs[11] = '{4'd2,  4'h5, 1'b0};

      // reset: outputs held low even with x = 1
      rst         = 1'b1;
      bus_chk.x   = 1'b1;
      bus_nochk.x = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, "reset x1");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, "reset x0");
      rst = 1'b0;

      // table of digits, back-to-back with no idle cycles
      foreach (vecs[k]) begin
         run_digit(vecs[k].digit, vecs[k].exp_z, vecs[k].exp_err,
                   $sformatf("vec%0d d%0d", k, vecs[k].digit));
      end

      // back-to-back pair 0101 then 0111
      run_digit(4'd5, 4'h8, 1'b0, "pair first");
      run_digit(4'd7, 4'hA, 1'b0, "pair second");

      // reset after two bits of 1010, then 0011 -> 0110
      cyc(1'b0, 1'b1, 1'b0, 1'b0, "midrst b0");
      cyc(1'b1, 1'b0, 1'b0, 1'b0, "midrst b1");
      rst = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, "midrst hold0");
      cyc(1'b1, 1'b0, 1'b0, 1'b0, "midrst hold1");
      rst = 1'b0;
      run_digit(4'd3, 4'h6, 1'b0, "after midrst");

      // reset landing on the bit-3 cycle of 1010 suppresses err and last
      cyc(1'b0, 1'b1, 1'b0, 1'b0, "b3rst b0");
      cyc(1'b1, 1'b0, 1'b0, 1'b0, "b3rst b1");
      cyc(1'b0, 1'b1, 1'b0, 1'b0, "b3rst b2");
      rst = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, "b3rst hold");
      rst = 1'b0;
      run_digit(4'd9, 4'hC, 1'b0, "after b3rst");

      // long random run of valid digits
      bad_conv = 0;
      bad_err  = 0;
      for (int n = 0; n < 10000; n++) begin
         d = 4'($urandom_range(0, 9));
         rand_digit(d, zr, es);
         if (zr !== 4'(d + 4'd3)) begin
            bad_conv++;
            if (bad_conv <= 5) chk4($sformatf("rand conv d%0d", d), zr, 4'(d + 4'd3));
         end
         if (es !== 1'b0) begin
            bad_err++;
            if (bad_err <= 5) chk($sformatf("rand err d%0d", d), es, 1'b0);
         end
      end
      chk4("rand conv errors", 4'(bad_conv > 0 ? 1 : 0), 4'h0);
      chk4("rand err count",   4'(bad_err > 0 ? 1 : 0),  4'h0);

      // random sweep over all 16 codes: err exactly for 10..15
      for (int n = 0; n < 200; n++) begin
         d = 4'($urandom_range(0, 15));
         rand_digit(d, zr, es);
         exp_es = (d > 4'd9);
         chk4($sformatf("sweep conv d%0d", d), zr, 4'(d + 4'd3));
         chk($sformatf("sweep err d%0d", d), es, exp_es);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/bcd_to_excess3_serial.md
BCD_TO_EXCESS3_SERIAL -- requirements
Module: bcd_to_excess3_serial

Interface
REQ-001 Parameter: CHECK_BCD, default 1; 1 enables Err generation, 0 ties Err to 0.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Rst  input  1  synchronous, active-high reset, sampled on rising Clk.
REQ-004 X  input  1  serial BCD digit, LSB first, one bit per Clk cycle, 4 cycles per digit, no gaps between digits.
REQ-005 Z  output  1  serial Excess-3 bit (BCD + 3, mod 16), LSB first; Mealy output, bit-aligned with X.
REQ-006 Last  output  1  high during the cycle X carries bit 3 of a digit.
REQ-007 Err  output  1  Mealy flag, high during the bit-3 cycle when the digit in flight is greater than 9.

Function
REQ-008 The block SHALL be a Mealy FSM of 11 states.
  - S0: expecting bit 0.
  - S1_C0 / S1_C1: expecting bit 1, with carry.
  - S2_Cc_Hh: expecting bit 2, with carry c and flag h (h = bit1 seen as 1).
  - S3_Cc_Hh: expecting bit 3, with carry c and flag h (h = bit1 or bit2 seen as 1).
REQ-009 Z, Last and Err SHALL be combinational from current state and X; no registered output latency.
REQ-010 Z SHALL be valid from X change until the next rising Clk; the bench samples on falling Clk.
REQ-011 Bit 0 (S0): Z = ~X; next state S1_C<X>.
REQ-012 Bit 1 (adds 1 + carry): Z = ~(X ^ c); carry' = X | c; h' = X; next state S2.
REQ-013 Bit 2 (adds carry): Z = X ^ c; carry' = X & c; h' = h | X; next state S3.
REQ-014 Bit 3 (adds carry): Z = X ^ c; carry out discarded (mod-16 result); Last = 1; next state S0.
REQ-015 Err = CHECK_BCD & (state is S3_*_H1) & X; Err = 0 in all other states.
REQ-016 Invalid digits (10..15) SHALL still produce Z = (digit + 3) mod 16; the FSM SHALL return to S0 with no other side effect.
REQ-017 Back-to-back digits SHALL be supported: the cycle after bit 3 is bit 0 of the next digit, with no idle cycle.
REQ-018 Unreachable state encodings SHALL transition to S0 on the next Clk; outputs in those states SHALL be 0.

Reset
REQ-019 With Rst = 1 at a rising Clk, the next state SHALL be S0 regardless of current state or X.
REQ-020 While Rst = 1, Z, Last and Err SHALL be forced to 0.
REQ-021 Reset mid-digit SHALL abandon the partial digit; the first bit after Rst deasserts SHALL be treated as bit 0.
REQ-022 The power-up state is undefined until the first Rst; the bench SHALL apply Rst = 1 for at least 1 Clk before driving digits.

Verification
REQ-023 BCD 0000 (X = 0,0,0,0) -> Z = 1,1,0,0 (Excess-3 0011); Last high on cycle 4 only; Err = 0.
REQ-024 BCD 1001 (X = 1,0,0,1) -> Z = 0,0,1,1 (1100); Err = 0.
REQ-025 BCD 1010 (X = 0,1,0,1) -> Z = 1,0,1,1 (1101); Err = 1 on cycle 4 only; FSM in S0 afterwards. With CHECK_BCD = 0, the same stimulus -> Err = 0.
REQ-026 Digits 0101 then 0111 driven back-to-back -> Z digits 1000 then 1010, with no gap.
REQ-027 Rst = 1 asserted after 2 bits of a digit -> Z, Last and Err = 0 during reset; digit 0011 sent afterwards -> Z digit 0110.
REQ-028 10000 random digits 0..9 driven back-to-back, recovered LSB first -> each equals digit + 3; Err never asserted. A random-digit sweep of 0..15 -> Err = 1 exactly for digits 10..15.
